// File: rtl/one_byte_uart_rx.sv
// one_byte_uart_rx: 8N1 UART receiver (clk, rst, rx_in -> rx_data, rx_done, rx_err, rx_busy)
module one_byte_uart_rx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int BAUD_CNT  = CLK_FREQ / BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_err,
  output logic       rx_busy
);
  localparam int CW = $clog2(BAUD_CNT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state_q;
  logic          rx_meta_q, rx_s_q, rx_s_dly_q;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q, data_q;
  logic          done_q, err_q;
  logic          sample, boundary, fall;
  assign sample   = baud_q == CW'(BAUD_CNT / 2);
  assign boundary = baud_q == CW'(BAUD_CNT - 1);
  assign fall     = rx_s_dly_q & ~rx_s_q;
  assign rx_data  = data_q;
  assign rx_done  = done_q;
  assign rx_err   = err_q;
  assign rx_busy  = state_q != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= IDLE;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_s_dly_q <= 1'b1;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rx_meta_q  <= rx_in;
      rx_s_q     <= rx_meta_q;
      rx_s_dly_q <= rx_s_q;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      baud_q     <= (state_q == IDLE || boundary) ? '0 : baud_q + 1'b1;
      case (state_q)
        IDLE:  if (fall) state_q <= START;
        START: if (sample && rx_s_q) begin
                 state_q <= IDLE;
                 baud_q  <= '0;
               end else if (boundary) begin
                 state_q <= DATA;
                 bit_q   <= '0;
               end
        DATA: begin
          if (sample) shift_q[bit_q] <= rx_s_q;
          if (boundary) begin
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= STOP;
          end
        end
        // leave at mid-stop so a start edge half a bit later is still caught
        STOP: if (sample) begin
          state_q <= IDLE;
          baud_q  <= '0;
          if (rx_s_q) begin
            data_q <= shift_q;
            done_q <= 1'b1;
          end else err_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          baud_q  <= '0;
        end
      endcase
    end
endmodule

// File: tb/tb_one_byte_uart_rx.sv
// tb_one_byte_uart_rx: randomized and directed bench for one_byte_uart_rx
module tb_one_byte_uart_rx;
  localparam int BC = 16;
  logic clk = 0, rst = 1, rx_in = 1;
  logic [7:0] rx_data;
  logic rx_done, rx_err, rx_busy;
  int tests = 0, fails = 0;
  int cyc = 0, done_n = 0, err_n = 0, overlap = 0, dbl = 0, last_done_cyc = 0;
  logic prev_done = 0, prev_err = 0;
  logic [7:0] dq[$];
  logic [7:0] exp_data;

  one_byte_uart_rx #(.BAUD_CNT(BC)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in),
    .rx_data(rx_data), .rx_done(rx_done), .rx_err(rx_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_done) begin
      done_n++;
      dq.push_back(rx_data);
      last_done_cyc = cyc;
    end
    if (rx_err) err_n++;
    if (rx_done && rx_err) overlap++;
    if ((rx_done && prev_done) || (rx_err && prev_err)) dbl++;
    prev_done = rx_done;
    prev_err  = rx_err;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_in = f[i];
      idle(BC);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    logic [7:0] got;
    got = (dq.size() > 0) ? dq.pop_front() : 8'hxx;
    chk(tag, {24'd0, got}, {24'd0, exp});
  endtask

  task automatic frame(input string tag, input logic [7:0] b, input logic stop);
    int d0, e0;
    d0 = done_n;
    e0 = err_n;
    send(b, stop);
    if (stop) exp_data = b;
    chk({tag, "_done"}, done_n - d0, {31'd0, stop});
    chk({tag, "_err"}, err_n - e0, {31'd0, ~stop});
    if (stop) pop_chk({tag, "_byte"}, b);
    chk({tag, "_data"}, {24'd0, rx_data}, {24'd0, exp_data});
    chk({tag, "_busy"}, {31'd0, rx_busy}, 0);
    if (!stop) begin
      rx_in = 1'b1;
      idle(20);
    end
  endtask

  initial begin
    int st, d0, e0, lat;
    logic [7:0] b;
    logic s;
    exp_data = 8'h00;
    #1;
    chk("rst_data", {24'd0, rx_data}, 0);
    chk("rst_flags", {29'd0, rx_done, rx_err, rx_busy}, 0);
    idle(2);
    rst = 0;
    idle(10);

    st = cyc;
    frame("f55", 8'h55, 1'b1);
    lat = last_done_cyc - st;
    chk("latency", (lat >= 154 && lat <= 156) ? 1 : 0, 1);

    d0 = done_n;
    e0 = err_n;
    rx_in = 1'b0;
    idle(3);
    chk("false_start_busy", {31'd0, rx_busy}, 1);
    rx_in = 1'b1;
    idle(30);
    chk("false_start_idle", {31'd0, rx_busy}, 0);
    chk("false_start_pulses", (done_n - d0) + (err_n - e0), 0);
    chk("false_start_data", {24'd0, rx_data}, 8'h55);

    d0 = done_n;
    e0 = err_n;
    send(8'hA3, 1'b0);
    chk("ferr_err", err_n - e0, 1);
    chk("ferr_done", done_n - d0, 0);
    chk("ferr_data", {24'd0, rx_data}, 8'h55);
    idle(40);
    chk("ferr_low_idle", {31'd0, rx_busy}, 0);
    rx_in = 1'b1;
    idle(20);
    chk("ferr_no_restart", {31'd0, rx_busy}, 0);

    d0 = done_n;
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    chk("b2b_count", done_n - d0, 2);
    pop_chk("b2b_first", 8'h00);
    pop_chk("b2b_second", 8'hFF);
    exp_data = 8'hFF;
    idle(10);

    d0 = done_n;
    e0 = err_n;
    rx_in = 1'b0;
    idle(BC);
    for (int i = 0; i < 4; i++) begin
      rx_in = (i == 0);
      idle(BC);
    end
    rx_in = 1'b0;
    idle(5);
    chk("mid_busy", {31'd0, rx_busy}, 1);
    rst = 1;
    rx_in = 1'b1;
    #1;
    chk("mid_rst_data", {24'd0, rx_data}, 0);
    chk("mid_rst_flags", {29'd0, rx_done, rx_err, rx_busy}, 0);
    idle(2);
    rst = 0;
    exp_data = 8'h00;
    idle(40);
    chk("mid_pulses", (done_n - d0) + (err_n - e0), 0);
    chk("mid_data", {24'd0, rx_data}, 0);
    frame("f3c", 8'h3C, 1'b1);

    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 3) != 0);
      frame("rnd", b, s);
      idle($urandom_range(0, 10));
    end

    chk("no_overlap", overlap, 0);
    chk("no_double", dbl, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
